// File: rtl/ws2812b_stream_decoder_pkg.sv
// ws2812b_stream_decoder_pkg: shared WS2812B link timing (cycles @ 100 MHz) and decoder state type
package ws2812b_stream_decoder_pkg;
  localparam int WS_T0H        = 40;
  localparam int WS_T1H        = 80;
  localparam int WS_T_BIT      = 125;
  localparam int WS_T_MIN_HIGH = 20;
  localparam int WS_T_THRESH   = 63;
  localparam int WS_T_MAX_HIGH = 100;
  localparam int WS_T_RESET    = 5000;
  localparam int WS_CNT_W      = 13;
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_e;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/ws2812b_stream_decoder_edge_sync.sv
// ws2812b_stream_decoder_edge_sync: 2-flop synchronizer with registered rise/fall strobes
//  clk, reset : clock, synchronous active-high reset
//  din_i      : raw asynchronous serial line
//  level_o    : synchronized level, aligned with the strobes
//  rise_o     : one-cycle strobe on a rising edge of level_o
//  fall_o     : one-cycle strobe on a falling edge of level_o
module ws2812b_stream_decoder_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q, rise_q, fall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      {meta_q, sync_q, prev_q, rise_q, fall_q} <= '0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end
  // prev_q takes the new level on the same edge the strobe registers, so they line up
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/ws2812b_stream_decoder.sv
// ws2812b_stream_decoder: measures WS2812B high pulses and reassembles 24-bit GRB pixels
//  clk, reset  : clock, synchronous active-high reset
//  din         : raw asynchronous serial line
//  pixel_data  : last complete pixel, first received bit in [23]
//  pixel_valid : one-cycle strobe, pixel_data updated
//  pixel_count : pixels completed in the current frame (saturating)
//  frame_done  : one-cycle strobe on the latch gap, pixel_count valid
//  bit_error   : one-cycle strobe on any protocol violation
module ws2812b_stream_decoder
  import ws2812b_stream_decoder_pkg::*;
#(
  parameter int T_MIN_HIGH = WS_T_MIN_HIGH,
  parameter int T_THRESH   = WS_T_THRESH,
  parameter int T_MAX_HIGH = WS_T_MAX_HIGH,
  parameter int T_RESET    = WS_T_RESET,
  parameter int CNT_W      = WS_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_count,
  output logic        frame_done,
  output logic        bit_error
);
  // cnt_q at a falling edge holds (high width - 1), so thresholds are shifted by one
  localparam logic [CNT_W-1:0] GLITCH_LT = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE_GE    = CNT_W'(T_THRESH - 1);
  localparam logic [CNT_W-1:0] LONG_GE   = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] GAP_GE    = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(T_RESET);
  logic lvl, rise, fall, bit_in;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d;
  logic [22:0] shift_q, shift_d;
  logic [23:0] pix_q, pix_d;
  logic [7:0] pc_q, pc_d;
  logic pv_q, pv_d, fd_q, fd_d, be_q, be_d;
  ws2812b_stream_decoder_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (din),
    .level_o(lvl),
    .rise_o (rise),
    .fall_o (fall)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pix_q   <= '0;
      pc_q    <= '0;
      pv_q    <= 1'b0;
      fd_q    <= 1'b0;
      be_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pix_q   <= pix_d;
      pc_q    <= pc_d;
      pv_q    <= pv_d;
      fd_q    <= fd_d;
      be_q    <= be_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (rise || fall) ? '0 : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1));
    bit_d   = bit_q;
    shift_d = shift_q;
    pix_d   = pix_q;
    pv_d    = 1'b0;
    fd_d    = 1'b0;
    be_d    = 1'b0;
    // count survives the strobe cycle so it can be read alongside frame_done
    pc_d    = (fd_q || be_q) ? '0 : pc_q;
    bit_in  = cnt_q >= ONE_GE;
    case (state_q)
      SYNC: state_d = (!lvl && !fall && cnt_q >= GAP_GE) ? IDLE : SYNC;
      IDLE: state_d = rise ? HIGH : IDLE;
      HIGH: begin
        if (cnt_q >= LONG_GE || (fall && cnt_q < GLITCH_LT)) begin
          be_d    = 1'b1;
          bit_d   = '0;
          shift_d = '0;
          state_d = SYNC;
        end else if (fall) begin
          state_d = LOW;
          shift_d = {shift_q[21:0], bit_in};
          bit_d   = bit_q + 5'd1;
          if (bit_q == 5'd23) begin
            pix_d   = {shift_q, bit_in};
            pv_d    = 1'b1;
            bit_d   = '0;
            shift_d = '0;
            pc_d    = sat_inc8(pc_q);
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (cnt_q >= GAP_GE) begin
          fd_d    = 1'b1;
          be_d    = bit_q != '0;
          bit_d   = '0;
          shift_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end
  assign pixel_data  = pix_q;
  assign pixel_valid = pv_q;
  assign pixel_count = pc_q;
  assign frame_done  = fd_q;
  assign bit_error   = be_q;
endmodule

// File: tb/tb_ws2812b_stream_decoder.sv
// tb_ws2812b_stream_decoder: directed self-checking bench for the WS2812B stream decoder
module tb_ws2812b_stream_decoder;
  logic clk = 1'b0;
  logic reset, din;
  logic [23:0] pixel_data;
  logic pixel_valid, frame_done, bit_error;
  logic [7:0] pixel_count;
  int n_cmp = 0, n_bad = 0;
  logic [23:0] px_q[$];
  int fd_n = 0, fd_be = 0, be_n = 0, fd_pc = -1, pc_after = -1;
  logic fd_prev = 1'b0;
  int px0, fd0, fdbe0, be0;
  logic [23:0] frame2 [4] = '{24'h123456, 24'hABCDEF, 24'h000000, 24'hFFFFFF};
  ws2812b_stream_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_count(pixel_count),
    .frame_done (frame_done),
    .bit_error  (bit_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid) px_q.push_back(pixel_data);
      if (frame_done) begin
        fd_n++;
        fd_pc = int'(pixel_count);
        if (bit_error) fd_be++;
      end
      if (bit_error) be_n++;
      if (fd_prev) pc_after = int'(pixel_count);
      fd_prev = frame_done;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    hold(1'b1, b ? 80 : 40);
    hold(1'b0, b ? 45 : 85);
  endtask
  task automatic send_px(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask
  task automatic snap();
    px0 = px_q.size();
    fd0 = fd_n;
    fdbe0 = fd_be;
    be0 = be_n;
  endtask
  task automatic check_px(input string tag, input int idx, input logic [23:0] exp);
    if (px_q.size() > idx) check(tag, px_q[idx], exp);
    else check(tag, 32'hDEAD_0000 | 32'(px_q.size()), exp);
  endtask
  task automatic check_outs_zero(input string tag);
    check({tag, "_data"}, pixel_data, 0);
    check({tag, "_pv"}, pixel_valid, 0);
    check({tag, "_pc"}, pixel_count, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_be"}, bit_error, 0);
  endtask
  initial begin
    reset = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check_outs_zero("rst");
    reset = 1'b0;
    hold(1'b0, 5010);
    snap();
    send_px(24'hFF0055);
    hold(1'b0, 5010);
    check("t1_npx", px_q.size() - px0, 1);
    check_px("t1_px", px0, 24'hFF0055);
    check("t1_nfd", fd_n - fd0, 1);
    check("t1_pc", fd_pc, 1);
    check("t1_pc_clr", pc_after, 0);
    check("t1_be", be_n - be0, 0);
    snap();
    for (int i = 0; i < 4; i++) send_px(frame2[i]);
    hold(1'b0, 5010);
    check("t2_npx", px_q.size() - px0, 4);
    for (int i = 0; i < 4; i++) check_px($sformatf("t2_px%0d", i), px0 + i, frame2[i]);
    check("t2_nfd", fd_n - fd0, 1);
    check("t2_pc", fd_pc, 4);
    check("t2_be", be_n - be0, 0);
    snap();
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    hold(1'b0, 5010);
    check("t3_npx", px_q.size() - px0, 0);
    check("t3_be", be_n - be0, 1);
    check("t3_fdbe", fd_be - fdbe0, 1);
    check("t3_nfd", fd_n - fd0, 1);
    check("t3_pc", fd_pc, 0);
    snap();
    send_px(24'hA5C33C);
    hold(1'b0, 5010);
    check_px("t3_px", px0, 24'hA5C33C);
    check("t3_pc2", fd_pc, 1);
    check("t3_be2", be_n - be0, 0);
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    hold(1'b1, 15);
    hold(1'b0, 110);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    hold(1'b0, 5010);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    hold(1'b1, 150);
    hold(1'b0, 5010);
    check("t4_be", be_n - be0, 2);
    check("t4_nfd", fd_n - fd0, 0);
    check("t4_npx", px_q.size() - px0, 0);
    check("t4_hold", pixel_data, 24'hA5C33C);
    snap();
    send_px(24'h00FF00);
    hold(1'b0, 5010);
    check_px("t4_px", px0, 24'h00FF00);
    check("t4_pc", fd_pc, 1);
    check("t4_be2", be_n - be0, 0);
    snap();
    for (int i = 0; i < 12; i++) send_bit(i[1]);
    reset = 1'b1;
    din = 1'b1;
    @(negedge clk);
    check_outs_zero("t6_rst");
    hold(1'b1, 2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    check("t5_npx", px_q.size() - px0, 0);
    check("t5_nfd", fd_n - fd0, 0);
    check("t5_be", be_n - be0, 0);
    hold(1'b0, 5010);
    snap();
    send_px(24'h0F0F0F);
    hold(1'b0, 5010);
    check_px("t6_px", px0, 24'h0F0F0F);
    check("t6_pc", fd_pc, 1);
    check("t6_be", be_n - be0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
